// File: rtl/pwm_sd_dac.sv
// ---------------------------------------------------------------------------
// pwm_sd_dac
// Multi-channel 1-bit audio DAC modulator. Every channel converts an N-bit
// offset-binary sample (2^(N-1) = silence) into a 1-bit stream, using either
// PWM or a first-order sigma-delta modulator. All channels share one period
// counter, one sample strobe and one mode, so their outputs stay
// phase-aligned.
//
// Ports
//   clk            : single clock; all state changes on its rising edge
//   rst_n          : asynchronous active-low reset
//   i_value        : C*N bits, channel k sample at [k*N +: N]
//   i_strb         : captures i_value for all channels
//   i_mode         : 0 = PWM, 1 = sigma-delta (sampled only on the wrap cycle)
//   o_out          : C registered 1-bit modulated outputs
//   o_period_start : high while the period counter is 0
//   o_overrun      : sticky, set when a pending sample is overwritten
//
// Sample handshake: i_strb is a one-cycle qualifier with no back-pressure.
// A strobe on the wrap cycle (counter == 2^N-1) goes straight into the active
// registers. A strobe on any other cycle parks the sample in the pending
// registers, which move to active on the next wrap. A second strobe before
// that wrap replaces the pending sample and raises o_overrun.
// ---------------------------------------------------------------------------
module pwm_sd_dac #(
  parameter int VALUE_BITS = 9,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*VALUE_BITS-1:0] i_value,
  input  logic                           i_strb,
  input  logic                           i_mode,
  output logic [CHANNELS-1:0]            o_out,
  output logic                           o_period_start,
  output logic                           o_overrun
);

  localparam int N = VALUE_BITS;
  localparam logic [N-1:0] SILENCE = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0] cnt;
  logic [N-1:0] pending    [CHANNELS];
  logic [N-1:0] active     [CHANNELS];
  logic [N:0]   acc        [CHANNELS];
  logic [N:0]   sd_sum     [CHANNELS];
  logic         pend_valid;
  logic         mode_q;
  logic         wrap;
  logic         mode_change;

  assign wrap           = (cnt == {N{1'b1}});
  assign o_period_start = (cnt == {N{1'b0}});
  // Mode only moves on the wrap, so accumulators restart cleanly at the
  // first cycle of the new mode.
  assign mode_change    = wrap && (i_mode != mode_q);

  // Only the low N bits of the accumulator carry forward; bit N is the
  // carry that becomes the output bit.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      sd_sum[k] = {1'b0, acc[k][N-1:0]} + {1'b0, active[k]};
    end
  end

  // Period counter, sample buffering, mode and overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      pend_valid <= 1'b0;
      mode_q     <= 1'b0;
      o_overrun  <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        pending[k] <= '0;
        active[k]  <= SILENCE;
      end
    end else begin
      cnt <= cnt + 1'b1;
      if (wrap) begin
        mode_q     <= i_mode;
        pend_valid <= 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
          if (i_strb) begin
            active[k] <= i_value[k*N +: N];
          end else if (pend_valid) begin
            active[k] <= pending[k];
          end
        end
      end else if (i_strb) begin
        pend_valid <= 1'b1;
        if (pend_valid) begin
          o_overrun <= 1'b1;
        end
        for (int k = 0; k < CHANNELS; k++) begin
          pending[k] <= i_value[k*N +: N];
        end
      end
    end
  end

  // Modulators: output reflects the counter / accumulator step of the
  // previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        acc[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        o_out[k] <= mode_q ? sd_sum[k][N] : (cnt < active[k]);
        if (mode_change) begin
          acc[k] <= '0;
        end else if (mode_q) begin
          acc[k] <= sd_sum[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_sd_dac.sv
// ---------------------------------------------------------------------------
// tb_pwm_sd_dac
// Bench for pwm_sd_dac with N = 9, C = 2. A per-cycle behavioural model
// predicts {o_overrun, o_period_start, o_out}. Directed table vectors and
// hand sequences add period-level high counts, and a random phase follows.
// ---------------------------------------------------------------------------
module tb_pwm_sd_dac;

  localparam int N = 9;
  localparam int C = 2;
  localparam int P = 512;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [C*N-1:0] i_value = '0;
  logic           i_strb = 1'b0;
  logic           i_mode = 1'b0;
  logic [C-1:0]   o_out;
  logic           o_period_start;
  logic           o_overrun;

  pwm_sd_dac #(.VALUE_BITS(N), .CHANNELS(C)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_value        (i_value),
    .i_strb         (i_strb),
    .i_mode         (i_mode),
    .o_out          (o_out),
    .o_period_start (o_period_start),
    .o_overrun      (o_overrun)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase within the period, the duty currently playing, the sample queued
  // for the next period, and the sigma-delta running remainder.
  int m_cnt;
  int m_active [C];
  int m_next   [C];
  bit m_has_next;
  bit m_mode;
  bit m_ovr;
  int m_acc    [C];

  task automatic model_reset();
    m_cnt      = 0;
    m_has_next = 0;
    m_mode     = 0;
    m_ovr      = 0;
    for (int k = 0; k < C; k++) begin
      m_active[k] = P / 2;
      m_next[k]   = 0;
      m_acc[k]    = 0;
    end
  endtask

  // One clock: drive inputs, predict, clock, compare.
  task automatic step(input bit strb, input logic [N-1:0] v0, input logic [N-1:0] v1, input bit md);
    int vals [C];
    bit end_of_period;
    logic [1:0] lvl;
    @(negedge clk);
    i_strb  = strb;
    i_value = {v1, v0};
    i_mode  = md;
    vals[0] = int'(v0);
    vals[1] = int'(v1);
    end_of_period = (m_cnt == P - 1);
    for (int k = 0; k < C; k++) begin
      if (m_mode) lvl[k] = ((m_acc[k] % P) + m_active[k]) >= P;
      else        lvl[k] = m_cnt < m_active[k];
    end
    for (int k = 0; k < C; k++) begin
      if (end_of_period && (md != m_mode)) m_acc[k] = 0;
      else if (m_mode)                     m_acc[k] = (m_acc[k] % P) + m_active[k];
    end
    if (end_of_period) begin
      for (int k = 0; k < C; k++) begin
        if (strb)            m_active[k] = vals[k];
        else if (m_has_next) m_active[k] = m_next[k];
      end
      m_has_next = 0;
      m_mode     = md;
    end else if (strb) begin
      if (m_has_next) m_ovr = 1;
      for (int k = 0; k < C; k++) m_next[k] = vals[k];
      m_has_next = 1;
    end
    m_cnt = (m_cnt + 1) % P;
    exp_q.push_back({m_ovr, (m_cnt == 0), lvl});
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      check("cycle", {28'd0, o_overrun, o_period_start, o_out}, {28'd0, exp_q.pop_front()});
    end
  endtask

  task automatic idle_to(input int pos, input bit md);
    for (int i = 0; i < P && m_cnt != pos; i++) step(0, '0, '0, md);
  endtask

  // 512-cycle observation window; mode switches from md_a to md_b at sw.
  int w_hi0, w_hi1, w_first0, w_ps, w_gap_bad;
  int w_idx[$];
  task automatic run_window(input bit md_a, input int sw, input bit md_b);
    w_hi0 = 0; w_hi1 = 0; w_first0 = 0; w_ps = 0; w_gap_bad = 0;
    w_idx.delete();
    for (int i = 0; i < P; i++) begin
      step(0, '0, '0, (i < sw) ? md_a : md_b);
      if (o_out[0]) begin
        w_hi0++;
        w_idx.push_back(i);
        if (i < 128) w_first0++;
      end
      if (o_out[1]) w_hi1++;
      if (o_period_start) w_ps++;
    end
    for (int i = 1; i < w_idx.size(); i++) begin
      if (w_idx[i] - w_idx[i-1] != 4) w_gap_bad++;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    i_strb = 1'b0;
    i_mode = 1'b0;
    i_value = '0;
    #1;
    check("reset_outputs", {28'd0, o_overrun, o_period_start, o_out}, 32'b0100);
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int         pos;
    logic [N-1:0] v0;
    logic [N-1:0] v1;
    bit         mode;
    int         exp0;
    int         exp1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // strobe position, ch0, ch1, mode, expected highs per period ch0/ch1
    vecs[0] = '{100, 9'd511, 9'd0,   1'b0, 511, 0};
    vecs[1] = '{511, 9'd10,  9'd300, 1'b0, 10,  300};
    vecs[2] = '{5,   9'd1,   9'd256, 1'b0, 1,   256};
    vecs[3] = '{0,   9'd0,   9'd511, 1'b0, 0,   511};
    vecs[4] = '{200, 9'd128, 9'd384, 1'b1, 128, 384};
    vecs[5] = '{0,   9'd511, 9'd1,   1'b1, 511, 1};
    vecs[6] = '{50,  9'd255, 9'd3,   1'b0, 255, 3};

    model_reset();
    #2;
    do_reset();

    // Idle after reset: silence in both channels, one period_start per period.
    run_window(0, P, 0);
    check("idle_hi0_p1", w_hi0, 256);
    check("idle_hi1_p1", w_hi1, 256);
    check("idle_ps_p1",  w_ps,  1);
    run_window(0, P, 0);
    check("idle_hi0_p2", w_hi0, 256);
    check("idle_hi1_p2", w_hi1, 256);
    check("idle_ps_p2",  w_ps,  1);
    check("idle_ovr",    o_overrun, 0);

    // Table vectors: strobe at a counter position, measure the next period.
    for (int v = 0; v < 7; v++) begin
      idle_to(vecs[v].pos, vecs[v].mode);
      step(1, vecs[v].v0, vecs[v].v1, vecs[v].mode);
      idle_to(0, vecs[v].mode);
      run_window(vecs[v].mode, P, vecs[v].mode);
      check($sformatf("vec%0d_hi0", v), w_hi0, vecs[v].exp0);
      check($sformatf("vec%0d_hi1", v), w_hi1, vecs[v].exp1);
    end
    check("table_no_ovr", o_overrun, 0);

    // Wrap strobe leaves nothing pending: a later single strobe is no overrun.
    idle_to(511, 0);
    step(1, 9'd10, 9'd10, 0);
    idle_to(50, 0);
    step(1, 9'd40, 9'd40, 0);
    check("wrap_strb_no_pend", o_overrun, 0);
    idle_to(0, 0);
    run_window(0, P, 0);
    check("after_wrap_hi0", w_hi0, 40);

    // Two strobes in one period: overrun, newer sample wins, flag sticks.
    idle_to(10, 0);
    step(1, 9'd20, 9'd20, 0);
    idle_to(20, 0);
    step(1, 9'd30, 9'd30, 0);
    check("ovr_set", o_overrun, 1);
    idle_to(0, 0);
    run_window(0, P, 0);
    check("ovr_hi0", w_hi0, 30);
    run_window(0, P, 0);
    check("ovr_sticky", o_overrun, 1);

    // Sigma-delta 128: 128 pulses, spaced 4 apart.
    idle_to(400, 1);
    step(1, 9'd128, 9'd128, 1);
    idle_to(0, 1);
    run_window(1, P, 1);
    check("sd_hi0",   w_hi0, 128);
    check("sd_gaps",  w_gap_bad, 0);
    // Mode dropped mid-period: still sigma-delta until the wrap.
    run_window(1, 100, 0);
    check("sd_hold_hi0",   w_hi0, 128);
    check("sd_hold_first", w_first0, 32);
    check("sd_hold_gaps",  w_gap_bad, 0);
    // Following period is PWM: the first 128 cycles are solid high.
    run_window(0, P, 0);
    check("pwm_back_first", w_first0, 128);
    check("pwm_back_hi0",   w_hi0, 128);

    // Reset mid-period in sigma-delta mode.
    idle_to(0, 1);
    idle_to(300, 1);
    #1;
    do_reset();
    run_window(0, P, 0);
    check("post_rst_hi0", w_hi0, 256);
    check("post_rst_hi1", w_hi1, 256);
    check("post_rst_ovr", o_overrun, 0);

    // Random traffic against the model.
    begin
      bit md;
      md = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 699) == 0) md = ~md;
        step(($urandom_range(0, 199) == 0),
             N'($urandom_range(0, P - 1)),
             N'($urandom_range(0, P - 1)), md);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_sd_dac.md
PWM_SD_DAC -- requirements
Module: pwm_sd_dac

Interface
REQ-001 SHALL provide parameter VALUE_BITS, default 9, meaning sample width N in offset-binary, where 2^(N-1) is silence.
REQ-002 SHALL provide parameter CHANNELS, default 2, meaning number of independent modulator channels C.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port i_value, input, C*N bits: per-channel samples, channel k at bits [k*N +: N].
REQ-006 SHALL provide port i_strb, input, 1 bit: sample strobe that captures i_value for all channels.
REQ-007 SHALL provide port i_mode, input, 1 bit: modulation select, 0 = PWM, 1 = first-order sigma-delta.
REQ-008 SHALL provide port o_out, output, C bits: 1-bit modulated outputs, registered.
REQ-009 SHALL provide port o_period_start, output, 1 bit: high for one cycle when the period counter equals 0.
REQ-010 SHALL provide port o_overrun, output, 1 bit: sticky flag set when a pending sample is lost.

Function
REQ-011 SHALL run a free N-bit period counter that increments every cycle and wraps from 2^N-1 to 0.
REQ-012 SHALL drive o_period_start as a combinational decode of counter == 0.
REQ-013 SHALL keep two registers per channel: pending and active, plus one pending-valid flag.
REQ-014 SHALL treat the "wrap cycle" as the cycle in which counter == 2^N-1.
REQ-015 When i_strb is high and it is not the wrap cycle, SHALL load pending from i_value and set pending-valid.
REQ-016 On the wrap cycle with i_strb high, SHALL load active directly from i_value, bypassing pending, and clear pending-valid.
REQ-017 On the wrap cycle with i_strb low and pending-valid set, SHALL load active from pending and clear pending-valid.
REQ-018 On the wrap cycle with i_strb low and pending-valid clear, SHALL hold active unchanged.
REQ-019 When i_strb is high outside the wrap cycle while pending-valid is already set, SHALL set o_overrun and overwrite pending with the newer sample.
REQ-020 o_overrun SHALL remain set until reset; no other event clears it.
REQ-021 SHALL sample i_mode into a mode register only on the wrap cycle, so modulation never changes mid-period.
REQ-022 When the mode register changes value, SHALL clear all sigma-delta accumulators in the same cycle.
REQ-023 PWM mode: o_out[k] SHALL be registered as (counter < active[k]), using unsigned compare.
REQ-024 PWM mode: active = 0 SHALL give constant 0; active = 2^N-1 SHALL give 2^N-1 high cycles per 2^N-cycle period.
REQ-025 Sigma-delta mode: each channel SHALL hold an (N+1)-bit accumulator that updates as acc <= {1'b0, acc[N-1:0]} + active.
REQ-026 Sigma-delta mode: o_out[k] SHALL be registered as bit N of the updated accumulator (the carry).
REQ-027 Sigma-delta mode: the count of high outputs over any 2^N consecutive cycles with constant active SHALL equal active exactly.
REQ-028 Latency: output for counter value c, or for accumulator step t, SHALL appear one clock later.
REQ-029 Timing of a new active value: it SHALL first affect o_out in the cycle after counter returns to 0.
REQ-030 SHALL keep all channels sharing one counter, one strobe and one mode, so channel outputs are phase-aligned.

Reset
REQ-031 While rst_n is low, the counter SHALL be 0, every active register SHALL be 2^(N-1), and every pending register SHALL be 0.
REQ-032 While rst_n is low, pending-valid, o_overrun, the mode register (PWM), all accumulators and o_out SHALL be 0.
REQ-033 Reset asserted mid-period SHALL immediately abandon the period; after release, counting SHALL restart at 0 with o_period_start high.
REQ-034 After reset release with no strobe, each output SHALL produce a 50% duty silence pattern in PWM mode (256 high / 256 low for N = 9).

Verification (N = 9, C = 2)
REQ-035 SHALL cover: after reset, idle for 1024 cycles -> each o_out is high 256 cycles per period, o_period_start pulses every 512 cycles, and o_overrun = 0.
REQ-036 SHALL cover: strobe {ch1 = 9'd0, ch0 = 9'd511} at counter 100 -> the old duty holds until the wrap; next period ch0 is high 511 cycles and ch1 is high 0 cycles.
REQ-037 SHALL cover: strobe exactly on the wrap cycle with ch0 = 9'd10 -> the next period ch0 is high 10 cycles, and pending-valid = 0 afterwards.
REQ-038 SHALL cover: two strobes (20, then 30) in one period -> o_overrun = 1, the next period uses 30, and the flag persists through later periods.
REQ-039 SHALL cover: i_mode = 1 with ch0 = 9'd128 -> o_out[0] is high exactly 128 times in each 512-cycle window, pulses spaced every 4 cycles, and i_mode toggling mid-period takes effect only after the wrap.
REQ-040 SHALL cover: rst_n low at counter 300 in sigma-delta mode -> outputs go to 0 asynchronously; after release the block is in PWM mode at silence with the counter at 0.
